// File: rtl/pingpong_pkg.sv
// Shared types and constants for the ping-pong frame buffer.
package pingpong_pkg;

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam int STATS_W = 16;

endpackage

// File: rtl/sdp_ram_bank.sv
// One frame bank: simple dual-port RAM, synchronous write, registered read (1 cycle).
// No backpressure; the read register holds its value while rd_en is low.
module sdp_ram_bank #(
  parameter int ADDR_W     = 13,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Double-buffered frame store: writer fills one bank while the reader scans the other; 1-cycle read latency.
// Writer is stalled (wr_ready=0, writes dropped) until the reader releases its frame; PPFB_STATS_EN adds frame/drop counters.
module pingpong_frame_buffer
  import pingpong_pkg::*;
#(
  parameter  int DATA_WIDTH = 12,
  parameter  int COL_BITS   = 7,
  parameter  int ROW_BITS   = 6,
  localparam int ADDR_W     = ROW_BITS + COL_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_frame_done,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_frame_done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  frame_avail,
  output logic                  swap_pulse
`ifdef PPFB_STATS_EN
  ,
  output logic [STATS_W-1:0]    frame_cnt,
  output logic [STATS_W-1:0]    drop_cnt
`endif
);

  state_t                state, state_nxt;
  logic                  wr_bank;
  logic                  rd_done_flag;
  logic                  rd_ok;
  logic                  swap;
  logic                  wr_fire;
  logic                  rd_zero_q;
  logic                  rd_sel_q;
  logic [DATA_WIDTH-1:0] bank_rdata [2];

  assign rd_ok   = rd_done_flag | rd_frame_done | ~frame_avail;
  assign wr_fire = wr_en & wr_ready;

  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    case (state)
      S_FILL: begin
        if (wr_frame_done) begin
          if (rd_ok) swap = 1'b1;
          else       state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rd_ok) begin
          swap      = 1'b1;
          state_nxt = S_FILL;
        end
      end
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_FILL;
      wr_bank       <= 1'b0;
      wr_ready      <= 1'b1;
      frame_avail   <= 1'b0;
      rd_done_flag  <= 1'b0;
      swap_pulse    <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_zero_q     <= 1'b1;
      rd_sel_q      <= 1'b0;
    end else begin
      state         <= state_nxt;
      wr_ready      <= (state_nxt == S_FILL);
      swap_pulse    <= swap;
      rd_data_valid <= rd_en;
      if (swap) begin
        wr_bank      <= ~wr_bank;
        frame_avail  <= 1'b1;
        rd_done_flag <= 1'b0;
      end else if (rd_frame_done) begin
        rd_done_flag <= 1'b1;
      end
      // Capture which bank (and whether any frame) the read targets, using pre-swap values.
      if (rd_en) begin
        rd_zero_q <= ~frame_avail;
        rd_sel_q  <= ~wr_bank;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sdp_ram_bank #(
      .ADDR_W     (ADDR_W),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_fire && (wr_bank == 1'(b))),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en && (wr_bank != 1'(b))),
      .rd_addr (rd_addr),
      .rd_data (bank_rdata[b])
    );
  end

  // The bank read registers hold when idle, so selecting through registered flags keeps rd_data stable.
  assign rd_data = rd_zero_q ? '0 : bank_rdata[rd_sel_q];

`ifdef PPFB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (swap) frame_cnt <= frame_cnt + STATS_W'(1);
      if (wr_en && !wr_ready && (drop_cnt != '1)) drop_cnt <= drop_cnt + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Bench for pingpong_frame_buffer: directed scenarios plus random traffic against a frame-level model.
module tb_pingpong_frame_buffer;
  import pingpong_pkg::*;

  localparam int DW    = 12;
  localparam int AW    = 13;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, wr_frame_done, wr_ready;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_en, rd_frame_done, rd_data_valid, frame_avail, swap_pulse;
`ifdef PPFB_STATS_EN
  logic [15:0]   frame_cnt, drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pingpong_frame_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_frame_done (wr_frame_done),
    .wr_ready      (wr_ready),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_frame_done (rd_frame_done),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .frame_avail   (frame_avail),
    .swap_pulse    (swap_pulse)
`ifdef PPFB_STATS_EN
    ,
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt)
`endif
  );

  // Frame-level model: which bank the writer owns, whether a finished frame is on display,
  // whether the reader has finished with it, and whether the writer is parked waiting.
  logic [DW-1:0] mem [2][DEPTH];
  bit            written [2][DEPTH];
  int            m_wb;
  bit            m_avail, m_reader_done, m_waiting, m_swap, m_valid;
  logic [DW-1:0] m_rdata;
  int            m_frames, m_drops;

  task automatic model_reset();
    m_wb = 0; m_avail = 0; m_reader_done = 0; m_waiting = 0;
    m_swap = 0; m_valid = 0; m_rdata = '0; m_frames = 0; m_drops = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; wr_en = 0; wr_frame_done = 0; rd_en = 0; rd_frame_done = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd, input bit fd,
                       input bit re, input int ra, input bit rfd);
    bit            free, sw, n_wait, n_valid;
    logic [DW-1:0] n_data;
    wr_en = we; wr_addr = AW'(wa); wr_data = wd; wr_frame_done = fd;
    rd_en = re; rd_addr = AW'(ra); rd_frame_done = rfd;
    free   = m_reader_done || rfd || !m_avail;
    sw     = m_waiting ? free : (fd && free);
    n_wait = m_waiting ? !free : (fd && !free);
    n_valid = re;
    n_data  = re ? (m_avail ? mem[1-m_wb][ra] : '0) : m_rdata;
    @(posedge clk); #1;
    if (we && !m_waiting) begin
      mem[m_wb][wa] = wd;
      written[m_wb][wa] = 1;
    end
    if (we && m_waiting && m_drops < 65535) m_drops++;
    if (sw) begin
      m_wb = 1 - m_wb; m_avail = 1; m_reader_done = 0;
      m_frames = (m_frames + 1) % 65536;
    end else if (rfd) begin
      m_reader_done = 1;
    end
    m_waiting = n_wait; m_swap = sw; m_valid = n_valid; m_rdata = n_data;
    wr_en = 0; wr_frame_done = 0; rd_en = 0; rd_frame_done = 0;
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%0b exp=1", wr_ready); end
    total++; if (frame_avail !== 1'b0) begin bad++; $display("FAIL reset_frame_avail got=%0b exp=0", frame_avail); end
    total++; if (swap_pulse !== 1'b0) begin bad++; $display("FAIL reset_swap_pulse got=%0b exp=0", swap_pulse); end
    total++; if (rd_data_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_data_valid); end
    total++; if (rd_data !== 12'h000) begin bad++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
`ifdef PPFB_STATS_EN
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
`endif
  endtask

  task automatic test_read_before_frame();
    drive(1, 5, 12'hABC, 0, 0, 0, 0);
    drive(0, 0, '0, 0, 1, 5, 0);
    total++; if (rd_data_valid !== 1'b1) begin bad++; $display("FAIL nofr_valid got=%0b exp=1", rd_data_valid); end
    total++; if (rd_data !== 12'h000) begin bad++; $display("FAIL nofr_data got=%0h exp=0", rd_data); end
  endtask

  task automatic test_first_swap();
    drive(0, 0, '0, 1, 0, 0, 0);
    total++; if (swap_pulse !== 1'b1) begin bad++; $display("FAIL swap1_pulse got=%0b exp=1", swap_pulse); end
    total++; if (frame_avail !== 1'b1) begin bad++; $display("FAIL swap1_avail got=%0b exp=1", frame_avail); end
    idle();
    total++; if (swap_pulse !== 1'b0) begin bad++; $display("FAIL swap1_pulse_width got=%0b exp=0", swap_pulse); end
    drive(0, 0, '0, 0, 1, 5, 0);
    total++; if (rd_data !== 12'hABC) begin bad++; $display("FAIL swap1_data got=%0h exp=abc", rd_data); end
    idle();
    total++; if (rd_data_valid !== 1'b0) begin bad++; $display("FAIL hold_valid got=%0b exp=0", rd_data_valid); end
    total++; if (rd_data !== 12'hABC) begin bad++; $display("FAIL hold_data got=%0h exp=abc", rd_data); end
  endtask

  task automatic test_hold_and_drop();
    drive(1, 5, 12'h123, 1, 0, 0, 0);
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL hold_wr_ready got=%0b exp=0", wr_ready); end
    total++; if (swap_pulse !== 1'b0) begin bad++; $display("FAIL hold_no_swap got=%0b exp=0", swap_pulse); end
    for (int i = 0; i < 3; i++) drive(1, 5, DW'($urandom), (i == 1), 0, 0, 0);
`ifdef PPFB_STATS_EN
    total++; if (drop_cnt !== 16'd3) begin bad++; $display("FAIL drop_cnt got=%0d exp=3", drop_cnt); end
`endif
    drive(0, 0, '0, 0, 1, 5, 0);
    total++; if (rd_data !== 12'hABC) begin bad++; $display("FAIL hold_read got=%0h exp=abc", rd_data); end
    drive(0, 0, '0, 0, 0, 0, 1);
    total++; if (swap_pulse !== 1'b1) begin bad++; $display("FAIL release_pulse got=%0b exp=1", swap_pulse); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL release_wr_ready got=%0b exp=1", wr_ready); end
    drive(0, 0, '0, 0, 1, 5, 0);
    total++; if (rd_data !== 12'h123) begin bad++; $display("FAIL release_data got=%0h exp=123", rd_data); end
  endtask

  task automatic test_simultaneous_done();
    drive(0, 0, '0, 1, 0, 0, 1);
    total++; if (swap_pulse !== 1'b1) begin bad++; $display("FAIL simul_pulse got=%0b exp=1", swap_pulse); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL simul_wr_ready got=%0b exp=1", wr_ready); end
    drive(0, 0, '0, 0, 1, 5, 0);
    total++; if (rd_data !== 12'hABC) begin bad++; $display("FAIL simul_data got=%0h exp=abc", rd_data); end
  endtask

  task automatic test_early_read_done();
    drive(0, 0, '0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      idle();
      total++; if (swap_pulse !== 1'b0) begin bad++; $display("FAIL early_spurious_swap cyc=%0d got=%0b exp=0", i, swap_pulse); end
    end
    drive(0, 0, '0, 1, 0, 0, 0);
    total++; if (swap_pulse !== 1'b1) begin bad++; $display("FAIL early_pulse got=%0b exp=1", swap_pulse); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL early_wr_ready got=%0b exp=1", wr_ready); end
  endtask

  task automatic test_swap_cycle_read();
    drive(1, 5, 12'h5A5, 0, 0, 0, 0);
    drive(0, 0, '0, 1, 1, 5, 1);
    total++; if (rd_data !== 12'h123) begin bad++; $display("FAIL swapcyc_data got=%0h exp=123", rd_data); end
    drive(0, 0, '0, 0, 1, 5, 0);
    total++; if (rd_data !== 12'h5A5) begin bad++; $display("FAIL postswap_data got=%0h exp=5a5", rd_data); end
`ifdef PPFB_STATS_EN
    total++; if (frame_cnt !== 16'd5) begin bad++; $display("FAIL frame_cnt got=%0d exp=5", frame_cnt); end
`endif
  endtask

  task automatic test_reset_in_hold();
    drive(0, 0, '0, 1, 0, 0, 0);
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL rhold_enter got=%0b exp=0", wr_ready); end
    apply_reset();
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rhold_wr_ready got=%0b exp=1", wr_ready); end
    total++; if (frame_avail !== 1'b0) begin bad++; $display("FAIL rhold_avail got=%0b exp=0", frame_avail); end
`ifdef PPFB_STATS_EN
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rhold_frame_cnt got=%0d exp=0", frame_cnt); end
`endif
    drive(0, 0, '0, 0, 1, 5, 0);
    total++; if (rd_data !== 12'h000) begin bad++; $display("FAIL rhold_read got=%0h exp=0", rd_data); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      bit we, fd, re, rfd;
      int wa, ra;
      we  = ($urandom_range(0, 1) == 1);
      re  = ($urandom_range(0, 1) == 1);
      fd  = ($urandom_range(0, 19) == 0);
      rfd = ($urandom_range(0, 14) == 0);
      wa  = $urandom_range(0, 31);
      ra  = $urandom_range(0, 31);
      if (re && m_avail && !written[1-m_wb][ra]) re = 0;
      drive(we, wa, DW'($urandom), fd, re, ra, rfd);
      total++; if (wr_ready !== !m_waiting) begin bad++; $display("FAIL rnd_wr_ready n=%0d got=%0b exp=%0b", n, wr_ready, !m_waiting); end
      total++; if (swap_pulse !== m_swap) begin bad++; $display("FAIL rnd_swap n=%0d got=%0b exp=%0b", n, swap_pulse, m_swap); end
      total++; if (frame_avail !== m_avail) begin bad++; $display("FAIL rnd_avail n=%0d got=%0b exp=%0b", n, frame_avail, m_avail); end
      total++; if (rd_data_valid !== m_valid) begin bad++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, rd_data_valid, m_valid); end
      total++; if (rd_data !== m_rdata) begin bad++; $display("FAIL rnd_data n=%0d got=%0h exp=%0h", n, rd_data, m_rdata); end
`ifdef PPFB_STATS_EN
      total++; if (frame_cnt !== 16'(m_frames)) begin bad++; $display("FAIL rnd_frame_cnt n=%0d got=%0d exp=%0d", n, frame_cnt, m_frames); end
      total++; if (drop_cnt !== 16'(m_drops)) begin bad++; $display("FAIL rnd_drop_cnt n=%0d got=%0d exp=%0d", n, drop_cnt, m_drops); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_read_before_frame();
    test_first_swap();
    test_hold_and_drop();
    test_simultaneous_done();
    test_early_read_done();
    test_swap_cycle_read();
    test_reset_in_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
